uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmit side of the 115.2 kbps UART between two byte-stream requesters (requester 0: debug monitor, requester 1: NES console/log path). Each requester gets a small FIFO. A round-robin arbiter with an optional per-requester lock drains the FIFOs one byte at a time into the UART's TX_DATA / TX_DATA_EN / TX_BUSY handshake. The block sits between the requesters and the UART and is the only driver of the UART transmit inputs.

## Interface
- DEPTH, 4: entries per requester FIFO; power of two, 2..16.
- BUSY_TMO, 4: cycles allowed after UTX_EN for UTX_BUSY to rise.
- CLK  in  1  main clock, same clock as the UART.
- RESETB  in  1  reset, asynchronous, active-low.
- REQ0_DATA  in  8  requester 0 byte.
- REQ0_WE  in  1  requester 0 write strobe, one byte per cycle high.
- REQ0_LOCK  in  1  requester 0 keeps the grant across bytes while high.
- REQ0_FULL  out  1  requester 0 FIFO holds DEPTH entries.
- REQ1_DATA, REQ1_WE, REQ1_LOCK, REQ1_FULL: same as requester 0, for requester 1.
- UTX_DATA  out  8  to UART TX_DATA.
- UTX_EN  out  1  to UART TX_DATA_EN; single-cycle pulse.
- UTX_BUSY  in  1  from UART TX_BUSY.
- GRANT  out  2  one-hot owner of the byte in flight or of the lock; 00 when none.
- ERR  out  1  sticky flag: UTX_BUSY timeout seen.

## Operation
- Reset values: FIFOs empty, REQx_FULL=0, UTX_DATA=8'h00, UTX_EN=0, GRANT=00, ERR=0, state=IDLE, round-robin pointer `last`=1 (so requester 0 wins first).
- FIFO writes:
  - A write is accepted when REQx_WE=1 and REQx_FULL=0.
  - A write while full is dropped silently. FULL uses the pre-edge count, so a write is dropped even if the same FIFO pops that cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- States: IDLE, SEND, WAIT_RISE, WAIT_FALL.
- IDLE, issue condition is UTX_BUSY=0 and an eligible FIFO is non-empty.
  - Eligibility when GRANT is set (lock held): only the locked owner is eligible.
  - Eligibility otherwise: a requester is eligible if its FIFO is non-empty. If both are, the requester != `last` wins.
  - On issue: pop the head into UTX_DATA, UTX_EN<=1, set GRANT and `last` to the winner, go to SEND.
- SEND: UTX_EN<=0, tmo counter<=0, go to WAIT_RISE.
- WAIT_RISE:
  - UTX_BUSY=1: go to WAIT_FALL.
  - Otherwise increment tmo. When tmo reaches BUSY_TMO-1, set ERR=1 and go to IDLE (byte lost).
- WAIT_FALL: when UTX_BUSY=0, go to IDLE.
  - If the owner's LOCK=1, keep GRANT.
  - Otherwise GRANT<=00.
- Lock:
  - LOCK is sampled at WAIT_FALL exit.
  - While the grant is held and the owner's FIFO is empty, the block stays in IDLE with GRANT held, and the other requester waits.
  - When the owner drops LOCK while in IDLE with the grant held, GRANT clears on the next edge.
- UTX_EN is never asserted while UTX_BUSY=1 or outside IDLE->SEND.
- Reset mid-frame aborts everything; the UART is reset by the same RESETB.

## Timing
- Edge k, IDLE issues: UTX_EN=1 and UTX_DATA valid in cycle k..k+1. The UART samples them at edge k+1 and drives UTX_BUSY=1 after edge k+1.
- State is WAIT_RISE after edge k+1. It sees BUSY=1 and moves to WAIT_FALL at edge k+2.
- Byte-to-byte: the next UTX_EN rises one edge after UTX_BUSY is seen low in WAIT_FALL (IDLE), plus one edge for the issue itself.
- Write-to-UTX_EN latency with an empty FIFO and an idle UART: 2 edges (edge 1 writes the FIFO, edge 2 issues).
- REQx_FULL updates on the edge that changes the count.

## Test plan
- Single byte: REQ0 writes 8'hA5, BUSY model rises 1 cycle after EN and stays high 1890 cycles -> exactly one UTX_EN pulse with UTX_DATA=A5, GRANT=01 during the frame, GRANT=00 and IDLE after BUSY falls.
- Round-robin: REQ0 writes 01,02 and REQ1 writes 11,12 in the same cycles -> UART sequence 01,11,02,12; never two UTX_EN pulses without an intervening BUSY high/low.
- Lock: REQ1_LOCK=1, REQ1 writes 21,22,23 while REQ0 holds 0F -> 21,22,23 then 0F after LOCK drops. With LOCK=1 and the REQ1 FIFO empty, GRANT stays 10 and 0F waits.
- Full and overflow: 5 writes to REQ0 with BUSY held high -> REQ0_FULL=1 after the 4th write, 5th byte dropped, 4 bytes sent in order. Write and pop in the same cycle at count 3 -> count stays 3.
- Timeout: BUSY tied 0 -> UTX_EN pulse, ERR=1 exactly BUSY_TMO cycles after SEND, next byte still issued, ERR stays 1 until RESETB.
- Reset mid-frame: RESETB low during WAIT_FALL with bytes queued -> all outputs at reset values immediately, FIFOs empty, no UTX_EN after release until a new write.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of uart_tx_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the requesters and the UART.
interface uart_tx_arbiter_if;
    logic [7:0] REQ0_DATA;
    logic       REQ0_WE;
    logic       REQ0_LOCK;
    logic       REQ0_FULL;
    logic [7:0] REQ1_DATA;
    logic       REQ1_WE;
    logic       REQ1_LOCK;
    logic       REQ1_FULL;
    logic [7:0] UTX_DATA;
    logic       UTX_EN;
    logic       UTX_BUSY;
    logic [1:0] GRANT;
    logic       ERR;

    modport slave (
        input  REQ0_DATA, REQ0_WE, REQ0_LOCK,
        input  REQ1_DATA, REQ1_WE, REQ1_LOCK,
        input  UTX_BUSY,
        output REQ0_FULL, REQ1_FULL,
        output UTX_DATA, UTX_EN, GRANT, ERR
    );

    modport master (
        output REQ0_DATA, REQ0_WE, REQ0_LOCK,
        output REQ1_DATA, REQ1_WE, REQ1_LOCK,
        output UTX_BUSY,
        input  REQ0_FULL, REQ1_FULL,
        input  UTX_DATA, UTX_EN, GRANT, ERR
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two per-requester byte FIFOs drained round-robin (with optional lock) into one UART TX port.
// A BUSY that never rises after UTX_EN sets a sticky ERR and the byte is dropped.
module uart_tx_arbiter #(
    parameter int DEPTH    = 4,
    parameter int BUSY_TMO = 4
) (
    input  logic               CLK,
    input  logic               RESETB,
    uart_tx_arbiter_if.slave   bus
);
    localparam int NREQ = 2;
    localparam int AW   = $clog2(DEPTH);
    localparam int TW   = $clog2(BUSY_TMO) + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RISE, WAIT_FALL} state_t;

    logic [NREQ-1:0][7:0] wdata;
    logic [NREQ-1:0][7:0] head;
    logic [NREQ-1:0]      we, lock, full, nempty, pop;

    assign wdata = {bus.REQ1_DATA, bus.REQ0_DATA};
    assign we    = {bus.REQ1_WE,   bus.REQ0_WE};
    assign lock  = {bus.REQ1_LOCK, bus.REQ0_LOCK};

    assign bus.REQ0_FULL = full[0];
    assign bus.REQ1_FULL = full[1];

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        logic [DEPTH-1:0][7:0] mem_q;
        logic [AW-1:0]         wp_q, rp_q;
        logic [AW:0]           cnt_q;
        logic                  push;

        // FULL comes from the registered count, so a write at DEPTH is dropped even if this edge pops
        assign full[g]   = (cnt_q == (AW+1)'(DEPTH));
        assign nempty[g] = (cnt_q != '0);
        assign head[g]   = mem_q[rp_q];
        assign push      = we[g] & ~full[g];

        always_ff @(posedge CLK or negedge RESETB) begin
            if (!RESETB) begin
                mem_q <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wp_q] <= wdata[g];
                    wp_q        <= wp_q + 1'b1;
                end
                if (pop[g]) rp_q <= rp_q + 1'b1;
                if (push && !pop[g])      cnt_q <= cnt_q + 1'b1;
                else if (!push && pop[g]) cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_q, last_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            owner, go, win;

    assign owner = grant_q[1];

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        data_d  = data_q;
        en_d    = 1'b0;
        pop     = '0;
        go      = 1'b0;
        win     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_q != 2'b00) begin
                    // A held lock serves only its owner; releasing it costs one idle edge
                    if (!lock[owner]) begin
                        grant_d = 2'b00;
                    end else if (!bus.UTX_BUSY && nempty[owner]) begin
                        go  = 1'b1;
                        win = owner;
                    end
                end else if (!bus.UTX_BUSY && (|nempty)) begin
                    go  = 1'b1;
                    win = (&nempty) ? ~last_q : nempty[1];
                end
                if (go) begin
                    pop[win] = 1'b1;
                    data_d   = head[win];
                    en_d     = 1'b1;
                    grant_d  = win ? 2'b10 : 2'b01;
                    last_d   = win;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (bus.UTX_BUSY) begin
                    state_d = WAIT_FALL;
                end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    if (!lock[owner]) grant_d = 2'b00;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!bus.UTX_BUSY) begin
                    state_d = IDLE;
                    if (!lock[owner]) grant_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.UTX_DATA = data_q;
    assign bus.UTX_EN   = en_q;
    assign bus.GRANT    = grant_q;
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART BUSY model and a byte monitor.
module tb_uart_tx_arbiter;
    localparam int FRAME = 1890;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.DEPTH(4), .BUSY_TMO(4)) dut (
        .CLK(clk),
        .RESETB(rstb),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [1:0] st;
    logic [2:0] cnt0;
    assign st   = dut.state_q;
    assign cnt0 = dut.g_fifo[0].cnt_q;

    // UART model: BUSY rises the edge after it sees UTX_EN and stays high FRAME cycles
    logic force1 = 1'b0;
    logic tie0   = 1'b0;
    int   bcnt;
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bus.UTX_BUSY <= 1'b0;
            bcnt         <= 0;
        end else if (force1) begin
            bus.UTX_BUSY <= 1'b1;
            bcnt         <= 0;
        end else if (tie0) begin
            bus.UTX_BUSY <= 1'b0;
        end else if (!bus.UTX_BUSY) begin
            if (bus.UTX_EN) begin
                bus.UTX_BUSY <= 1'b1;
                bcnt         <= FRAME - 1;
            end
        end else if (bcnt == 0) begin
            bus.UTX_BUSY <= 1'b0;
        end else begin
            bcnt <= bcnt - 1;
        end
    end

    // Monitor: records every byte sent; viol counts EN while busy or two ENs with no BUSY between
    logic [7:0] sent[$];
    int   en_cnt = 0;
    int   viol = 0;
    logic pending = 1'b0;
    always @(negedge clk) begin
        if (!rstb) begin
            pending <= 1'b0;
        end else begin
            if (bus.UTX_EN) begin
                sent.push_back(bus.UTX_DATA);
                en_cnt <= en_cnt + 1;
                if (bus.UTX_BUSY || pending) viol <= viol + 1;
                pending <= 1'b1;
            end else if (bus.UTX_BUSY) begin
                pending <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
        tick();
    endtask

    task automatic wait_sent(input int n, input string tag);
        int i;
        for (i = 0; i < 20000; i++) begin
            if (sent.size() >= n && !bus.UTX_BUSY && st == 2'd0) break;
            tick();
        end
        if (i == 20000) chk({tag, "_wait_timeout"}, 0, 1);
    endtask

    int base, e0, v0, i0;

    initial begin
        bus.REQ0_DATA = 8'h00; bus.REQ0_WE = 1'b0; bus.REQ0_LOCK = 1'b0;
        bus.REQ1_DATA = 8'h00; bus.REQ1_WE = 1'b0; bus.REQ1_LOCK = 1'b0;

        // Reset values
        do_reset();
        chk("rst_full0", bus.REQ0_FULL, 0);
        chk("rst_full1", bus.REQ1_FULL, 0);
        chk("rst_data",  bus.UTX_DATA, 8'h00);
        chk("rst_en",    bus.UTX_EN, 0);
        chk("rst_grant", bus.GRANT, 2'b00);
        chk("rst_err",   bus.ERR, 0);
        chk("rst_state", st, 2'd0);

        // Single byte: write at edge 1, issue at edge 2
        base = sent.size(); e0 = en_cnt;
        bus.REQ0_DATA = 8'hA5; bus.REQ0_WE = 1'b1;
        tick();
        bus.REQ0_WE = 1'b0;
        chk("single_en_early", bus.UTX_EN, 0);
        tick();
        chk("single_en",    bus.UTX_EN, 1);
        chk("single_data",  bus.UTX_DATA, 8'hA5);
        chk("single_grant", bus.GRANT, 2'b01);
        tick();
        chk("single_en_pulse", bus.UTX_EN, 0);
        repeat (5) tick();
        chk("single_grant_frame", bus.GRANT, 2'b01);
        wait_sent(base + 1, "single");
        chk("single_grant_end", bus.GRANT, 2'b00);
        chk("single_state_end", st, 2'd0);
        chk("single_en_count", en_cnt - e0, 1);
        chk("single_byte", sent[base], 8'hA5);

        // Round-robin from reset: requester 0 first
        do_reset();
        base = sent.size(); v0 = viol;
        bus.REQ0_DATA = 8'h01; bus.REQ1_DATA = 8'h11; bus.REQ0_WE = 1'b1; bus.REQ1_WE = 1'b1;
        tick();
        bus.REQ0_DATA = 8'h02; bus.REQ1_DATA = 8'h12;
        tick();
        bus.REQ0_WE = 1'b0; bus.REQ1_WE = 1'b0;
        wait_sent(base + 4, "rr");
        chk("rr_b0", sent[base],   8'h01);
        chk("rr_b1", sent[base+1], 8'h11);
        chk("rr_b2", sent[base+2], 8'h02);
        chk("rr_b3", sent[base+3], 8'h12);

        // Lock: requester 1 keeps the grant, 0F waits until LOCK drops
        do_reset();
        base = sent.size();
        bus.REQ1_LOCK = 1'b1;
        bus.REQ1_DATA = 8'h21; bus.REQ1_WE = 1'b1;
        tick();
        bus.REQ1_DATA = 8'h22; bus.REQ0_DATA = 8'h0F; bus.REQ0_WE = 1'b1;
        tick();
        chk("lock_grant_first", bus.GRANT, 2'b10);
        bus.REQ1_DATA = 8'h23; bus.REQ0_WE = 1'b0;
        tick();
        bus.REQ1_WE = 1'b0;
        wait_sent(base + 3, "lock");
        repeat (10) tick();
        chk("lock_grant_held", bus.GRANT, 2'b10);
        chk("lock_0f_waits", sent.size() - base, 3);
        bus.REQ1_LOCK = 1'b0;
        tick();
        chk("lock_release_grant", bus.GRANT, 2'b00);
        chk("lock_release_en", bus.UTX_EN, 0);
        tick();
        chk("lock_0f_en",   bus.UTX_EN, 1);
        chk("lock_0f_data", bus.UTX_DATA, 8'h0F);
        wait_sent(base + 4, "lock_tail");
        chk("lock_b0", sent[base],   8'h21);
        chk("lock_b1", sent[base+1], 8'h22);
        chk("lock_b2", sent[base+2], 8'h23);
        chk("lock_b3", sent[base+3], 8'h0F);
        chk("handshake_viol", viol - v0, 0);

        // Full and overflow with BUSY held high
        do_reset();
        base = sent.size(); e0 = en_cnt;
        force1 = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.REQ0_DATA = 8'h31 + 8'(k); bus.REQ0_WE = 1'b1;
            tick();
            if (k == 2) chk("full_after3", bus.REQ0_FULL, 0);
            if (k == 3) chk("full_after4", bus.REQ0_FULL, 1);
            if (k == 4) chk("full_after5", bus.REQ0_FULL, 1);
        end
        bus.REQ0_WE = 1'b0;
        chk("full_no_en", en_cnt - e0, 0);
        force1 = 1'b0;
        wait_sent(base + 4, "full");
        repeat (20) tick();
        chk("full_sent_cnt", sent.size() - base, 4);
        chk("full_b0", sent[base],   8'h31);
        chk("full_b1", sent[base+1], 8'h32);
        chk("full_b2", sent[base+2], 8'h33);
        chk("full_b3", sent[base+3], 8'h34);
        chk("full_clear", bus.REQ0_FULL, 0);

        // Simultaneous write and pop at count 3
        do_reset();
        base = sent.size();
        force1 = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.REQ0_DATA = 8'h61 + 8'(k); bus.REQ0_WE = 1'b1;
            tick();
        end
        bus.REQ0_WE = 1'b0;
        chk("wp_cnt_before", cnt0, 3);
        force1 = 1'b0;
        tick();
        bus.REQ0_DATA = 8'h64; bus.REQ0_WE = 1'b1;
        tick();
        bus.REQ0_WE = 1'b0;
        chk("wp_en",        bus.UTX_EN, 1);
        chk("wp_data",      bus.UTX_DATA, 8'h61);
        chk("wp_cnt_after", cnt0, 3);
        wait_sent(base + 4, "wp");
        chk("wp_b3", sent[base+3], 8'h64);

        // Timeout: BUSY never rises
        do_reset();
        tie0 = 1'b1;
        bus.REQ0_DATA = 8'h41; bus.REQ0_WE = 1'b1;
        tick();
        bus.REQ0_DATA = 8'h42;
        tick();
        bus.REQ0_WE = 1'b0;
        chk("tmo_en1",   bus.UTX_EN, 1);
        chk("tmo_data1", bus.UTX_DATA, 8'h41);
        tick();
        repeat (3) tick();
        chk("tmo_err_early", bus.ERR, 0);
        tick();
        chk("tmo_err_set", bus.ERR, 1);
        chk("tmo_state",   st, 2'd0);
        tick();
        chk("tmo_en2",   bus.UTX_EN, 1);
        chk("tmo_data2", bus.UTX_DATA, 8'h42);
        repeat (10) tick();
        chk("tmo_err_sticky", bus.ERR, 1);
        tie0 = 1'b0;

        // Reset mid-frame with bytes queued
        bus.REQ0_WE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.REQ0_DATA = 8'h51 + 8'(k);
            tick();
        end
        bus.REQ0_WE = 1'b0;
        for (i0 = 0; i0 < 100 && st != 2'd3; i0++) tick();
        chk("mid_reached_wait_fall", st, 2'd3);
        chk("mid_err_before", bus.ERR, 1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_en",    bus.UTX_EN, 0);
        chk("mid_rst_data",  bus.UTX_DATA, 8'h00);
        chk("mid_rst_grant", bus.GRANT, 2'b00);
        chk("mid_rst_err",   bus.ERR, 0);
        chk("mid_rst_state", st, 2'd0);
        chk("mid_rst_cnt",   cnt0, 0);
        @(negedge clk);
        rstb = 1'b1;
        e0 = en_cnt;
        repeat (50) tick();
        chk("mid_no_en", en_cnt - e0, 0);
        bus.REQ0_DATA = 8'h5A; bus.REQ0_WE = 1'b1;
        tick();
        bus.REQ0_WE = 1'b0;
        tick();
        chk("mid_new_en",   bus.UTX_EN, 1);
        chk("mid_new_data", bus.UTX_DATA, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
